decode_control_stage: RTL and testbench

Registered, handshaked successor to the combinational decode control unit. Decodes opcode/funct3 into the execute-stage control bundle, holds it in a one-entry pipeline register with valid/ready flow control, supports flush, and detects load-use hazards, inserting a configurable number of bubbles. Sits between instruction fetch/decode and execute.

---
 rtl/decode_control_stage_if.sv | 41 ++++
 rtl/decode_control_stage.sv | 181 ++++++++++++++++++
 tb/tb_decode_control_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_control_stage_if.sv
// Handshake and control-bundle bus between decode and execute for decode_control_stage.
// slave: the stage itself; master: the upstream/downstream environment driving it.
interface decode_control_stage_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic                  d_cache_access;
    logic                  d_cache_op;
    logic                  branch;
    logic                  reg_write;
    logic                  alu_src;
    logic                  is_imm;
    logic                  is_byte_op;
    logic [1:0]            alu_op;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  illegal;
    logic                  stall;

    modport slave (
        input  in_valid, opcode, funct3, rd, rs1, rs2, flush, out_ready,
        output in_ready, out_valid, d_cache_access, d_cache_op, branch,
               reg_write, alu_src, is_imm, is_byte_op, alu_op, out_rd,
               illegal, stall
    );

    modport master (
        output in_valid, opcode, funct3, rd, rs1, rs2, flush, out_ready,
        input  in_ready, out_valid, d_cache_access, d_cache_op, branch,
               reg_write, alu_src, is_imm, is_byte_op, alu_op, out_rd,
               illegal, stall
    );
endinterface

// File: rtl/decode_control_stage.sv
// Registered decode stage: opcode/funct3 -> execute control bundle behind a valid/ready register.
// Load-use interlock is built only when DECODE_LOAD_USE_INTERLOCK_EN is defined.
module decode_control_stage #(
    parameter int REG_ADDR_W       = 5,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_control_stage_if.slave bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JUMP   = 7'b1100111;

    typedef struct packed {
        logic       d_cache_access;
        logic       d_cache_op;
        logic       branch;
        logic       reg_write;
        logic       alu_src;
        logic       is_imm;
        logic       is_byte_op;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t                 dec;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  is_load;

    ctrl_t                 ctrl_q, ctrl_d;
    logic                  out_valid_q, out_valid_d;
    logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;

    logic                  advance;
    logic                  in_ready_c;
    logic                  accept;
    logic                  stall_c;

    // Instruction decode; opcode 0000011 doubles as immediate ALU for non-load funct3 values.
    always_comb begin
        dec      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_load  = 1'b0;
        case (bus.opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1 = 1'b1;
                if (bus.funct3 == 3'b000 || bus.funct3 == 3'b010 || bus.funct3 == 3'b011) begin
                    is_load            = 1'b1;
                    dec.reg_write      = 1'b1;
                    dec.alu_src        = 1'b1;
                    dec.d_cache_access = 1'b1;
                    dec.d_cache_op     = 1'b1;
                    dec.is_byte_op     = (bus.funct3 == 3'b000);
                end else begin
                    dec.reg_write = 1'b1;
                    dec.is_imm    = 1'b1;
                end
            end
            OP_STORE: begin
                dec.d_cache_access = 1'b1;
                dec.d_cache_op     = 1'b0;
                dec.alu_src        = 1'b1;
                dec.is_byte_op     = (bus.funct3 == 3'b000);
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_JUMP: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b11;
                uses_rs1   = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign advance    = !out_valid_q || bus.out_ready;
    assign in_ready_c = advance && !stall_c && !bus.flush;
    assign accept     = bus.in_valid && in_ready_c;

    // Output register next state: flush beats accept, an idle advance leaves a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        out_rd_d    = out_rd_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec;
            out_rd_d    = bus.rd;
        end else if (advance) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            out_rd_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            out_rd_q    <= out_rd_d;
        end
    end

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    logic [REG_ADDR_W-1:0] haz_rd_q, haz_rd_d;
    logic [1:0]            haz_cnt_q, haz_cnt_d;

    // The count only moves when the stage advances, so backpressure never eats separation.
    always_comb begin
        haz_rd_d  = haz_rd_q;
        haz_cnt_d = haz_cnt_q;
        if (bus.flush) begin
            haz_cnt_d = 2'd0;
        end else if (accept && is_load && (bus.rd != '0)) begin
            haz_rd_d  = bus.rd;
            haz_cnt_d = 2'(LOAD_USE_BUBBLES);
        end else if (advance && (haz_cnt_q != 2'd0)) begin
            haz_cnt_d = haz_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haz_rd_q  <= '0;
            haz_cnt_q <= 2'd0;
        end else begin
            haz_rd_q  <= haz_rd_d;
            haz_cnt_q <= haz_cnt_d;
        end
    end

    assign stall_c = bus.in_valid && (haz_cnt_q != 2'd0) &&
                     ((uses_rs1 && (bus.rs1 == haz_rd_q)) ||
                      (uses_rs2 && (bus.rs2 == haz_rd_q)));
`else
    logic unused_haz;

    // Without the interlock, source registers and the load flag have no consumer.
    assign unused_haz = ^{bus.rs1, bus.rs2, uses_rs1, uses_rs2, is_load};
    assign stall_c    = 1'b0;
`endif

    assign bus.in_ready       = in_ready_c;
    assign bus.stall          = stall_c;
    assign bus.out_valid      = out_valid_q;
    assign bus.d_cache_access = ctrl_q.d_cache_access;
    assign bus.d_cache_op     = ctrl_q.d_cache_op;
    assign bus.branch         = ctrl_q.branch;
    assign bus.reg_write      = ctrl_q.reg_write;
    assign bus.alu_src        = ctrl_q.alu_src;
    assign bus.is_imm         = ctrl_q.is_imm;
    assign bus.is_byte_op     = ctrl_q.is_byte_op;
    assign bus.alu_op         = ctrl_q.alu_op;
    assign bus.illegal        = ctrl_q.illegal;
    assign bus.out_rd         = out_rd_q;

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage with LOAD_USE_BUBBLES=2; hazard expectations
// follow whether DECODE_LOAD_USE_INTERLOCK_EN is defined for the build.
module tb_decode_control_stage;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JUMP   = 7'b1100111;

    // Bundle order: {dca, dcop, branch, reg_write, alu_src, is_imm, is_byte, alu_op[1:0], illegal}
    localparam logic [9:0] B_R      = 10'b0001000_10_0;
    localparam logic [9:0] B_S_BYTE = 10'b1000101_00_0;
    localparam logic [9:0] B_S_WORD = 10'b1000100_00_0;
    localparam logic [9:0] B_LD_W   = 10'b1101100_00_0;
    localparam logic [9:0] B_LD_B   = 10'b1101101_00_0;
    localparam logic [9:0] B_IMM    = 10'b0001010_00_0;
    localparam logic [9:0] B_BR     = 10'b0010000_01_0;
    localparam logic [9:0] B_JMP    = 10'b0010000_11_0;
    localparam logic [9:0] B_ILL    = 10'b0000000_00_1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    decode_control_stage_if #(.REG_ADDR_W(5)) bus ();

    decode_control_stage #(
        .REG_ADDR_W      (5),
        .LOAD_USE_BUBBLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] bundle();
        return {bus.d_cache_access, bus.d_cache_op, bus.branch, bus.reg_write,
                bus.alu_src, bus.is_imm, bus.is_byte_op, bus.alu_op, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd_, input logic [4:0] rs1_, input logic [4:0] rs2_);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.rd       = rd_;
        bus.rs1      = rs1_;
        bus.rs2      = rs2_;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);

        // Reset state
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_bundle", bundle(), 0);
        check("rst_out_rd", bus.out_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", bus.in_ready, 1);

        // R-type then byte store, back to back
        drive(1'b1, OP_R, 3'b000, 5'd3, 5'd1, 5'd2);
        #1;
        check("r_in_ready", bus.in_ready, 1);
        tick();
        check("r_out_valid", bus.out_valid, 1);
        check("r_bundle", bundle(), B_R);
        check("r_out_rd", bus.out_rd, 3);
        drive(1'b1, OP_STORE, 3'b000, 5'd0, 5'd1, 5'd4);
        tick();
        check("sb_out_valid", bus.out_valid, 1);
        check("sb_bundle", bundle(), B_S_BYTE);
        drive(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("idle_bubble", bus.out_valid, 0);

        // Load rd=5 then R-type consuming rs2=5
        drive(1'b1, OP_LOAD, 3'b010, 5'd5, 5'd1, 5'd0);
        tick();
        check("lw_bundle", bundle(), B_LD_W);
        check("lw_out_rd", bus.out_rd, 5);
        drive(1'b1, OP_R, 3'b000, 5'd6, 5'd2, 5'd5);
        #1;
`ifdef DECODE_LOAD_USE_INTERLOCK_EN
        check("lu_stall1", bus.stall, 1);
        check("lu_in_ready1", bus.in_ready, 0);
        tick();
        check("lu_bubble1", bus.out_valid, 0);
        check("lu_stall2", bus.stall, 1);
        tick();
        check("lu_bubble2", bus.out_valid, 0);
        check("lu_stall_clear", bus.stall, 0);
        check("lu_in_ready3", bus.in_ready, 1);
        tick();
`else
        check("lu_nostall", bus.stall, 0);
        check("lu_in_ready", bus.in_ready, 1);
        tick();
`endif
        check("lu_consumer_valid", bus.out_valid, 1);
        check("lu_consumer_rd", bus.out_rd, 6);

        // Load to x0 never creates a hazard
        drive(1'b1, OP_LOAD, 3'b011, 5'd0, 5'd1, 5'd0);
        tick();
        drive(1'b1, OP_R, 3'b000, 5'd7, 5'd0, 5'd0);
        #1;
        check("x0_nostall", bus.stall, 0);
        tick();
        check("x0_consumer_valid", bus.out_valid, 1);
        check("x0_consumer_rd", bus.out_rd, 7);

        // Backpressure for 3 cycles holding a byte load, dependent consumer waiting
        drive(1'b1, OP_LOAD, 3'b000, 5'd10, 5'd1, 5'd0);
        tick();
        check("lb_bundle", bundle(), B_LD_B);
        bus.out_ready = 1'b0;
        drive(1'b1, OP_R, 3'b000, 5'd11, 5'd10, 5'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_rd", bus.out_rd, 10);
            check("bp_bundle", bundle(), B_LD_B);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
`ifdef DECODE_LOAD_USE_INTERLOCK_EN
        check("bp_stall_after_release", bus.stall, 1);
        tick();
        check("bp_bubble1", bus.out_valid, 0);
        tick();
        check("bp_bubble2", bus.out_valid, 0);
        check("bp_stall_clear", bus.stall, 0);
        tick();
`else
        check("bp_release_in_ready", bus.in_ready, 1);
        tick();
`endif
        check("bp_consumer_valid", bus.out_valid, 1);
        check("bp_consumer_rd", bus.out_rd, 11);
        drive(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("bp_no_duplicate", bus.out_valid, 0);

        // Flush with a held load and a pending dependent consumer
        drive(1'b1, OP_LOAD, 3'b010, 5'd9, 5'd1, 5'd0);
        tick();
        check("fl_load_valid", bus.out_valid, 1);
        drive(1'b1, OP_R, 3'b000, 5'd12, 5'd3, 5'd9);
        bus.flush = 1'b1;
        #1;
        check("fl_in_ready", bus.in_ready, 0);
        tick();
        check("fl_out_valid", bus.out_valid, 0);
        bus.flush = 1'b0;
        #1;
        check("fl_nostall", bus.stall, 0);
        check("fl_in_ready_after", bus.in_ready, 1);
        tick();
        check("fl_consumer_valid", bus.out_valid, 1);
        check("fl_consumer_rd", bus.out_rd, 12);
        check("fl_consumer_bundle", bundle(), B_R);

        // Remaining decode classes
        drive(1'b1, OP_LOAD, 3'b100, 5'd13, 5'd1, 5'd0);
        tick();
        check("imm_bundle", bundle(), B_IMM);
        drive(1'b1, OP_STORE, 3'b010, 5'd0, 5'd1, 5'd2);
        tick();
        check("sw_bundle", bundle(), B_S_WORD);
        drive(1'b1, OP_BRANCH, 3'b000, 5'd0, 5'd1, 5'd2);
        tick();
        check("br_bundle", bundle(), B_BR);
        drive(1'b1, OP_JUMP, 3'b000, 5'd1, 5'd1, 5'd0);
        tick();
        check("jmp_bundle", bundle(), B_JMP);
        drive(1'b1, 7'b1111111, 3'b000, 5'd14, 5'd13, 5'd13);
        tick();
        check("ill_bundle", bundle(), B_ILL);
        check("ill_out_rd", bus.out_rd, 14);

        // Asynchronous reset while a bundle is held
        drive(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        bus.out_ready = 1'b0;
        #2;
        check("pre_arst_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_bundle", bundle(), 0);
        check("arst_out_rd", bus.out_rd, 0);
        #2;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("arst_release_in_ready", bus.in_ready, 1);
        tick();
        check("arst_idle_valid", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
